// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : lsu_ctrl_if
// Brief  : CPU request/response and data-memory signal bundle for lsu_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    modport slave (
        input  req, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
        output busy, done, err, rdata, dm_addr, dm_din, dm_we
    );

    modport master (
        output req, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
        input  busy, done, err, rdata, dm_addr, dm_din, dm_we
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lsu_ctrl
// Brief  : Load/store unit controller; byte/half/word access with sign
//          extension and read-modify-write for sub-word stores.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lsu_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RCAP = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_cap;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_reject;
    logic [7:0]        w_lane;
    logic [15:0]       w_half;
    logic [31:0]       w_extract;
    logic [31:0]       w_merge;
    logic [ADDR_W-1:0] w_aligned;
    logic [4:0]        w_byte_base;
    logic [4:0]        w_half_base;

    assign w_reject = (bus.req_size == 2'b11) ||
                      ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    assign w_aligned   = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_byte_base = {r_addr[1:0], 3'b000};
    assign w_half_base = {r_addr[1], 4'b0000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cap    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req) begin
                r_we     <= bus.req_we;
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_err    <= w_reject;
            end
            if (r_state == RCAP) begin
                r_cap <= bus.dm_dout;
                if (!r_we) begin
                    r_rdata <= w_extract;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_reject)
                        w_next = DONE;
                    else if (bus.req_we && bus.req_size == 2'b10)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:      w_next = RCAP;
            RCAP:    w_next = r_we ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Load extraction operates on the word arriving during RCAP.
    always_comb begin
        w_lane    = bus.dm_dout[w_byte_base +: 8];
        w_half    = bus.dm_dout[w_half_base +: 16];
        w_extract = bus.dm_dout;
        case (r_size)
            2'b00:   w_extract = {{24{r_signed & w_lane[7]}}, w_lane};
            2'b01:   w_extract = {{16{r_signed & w_half[15]}}, w_half};
            default: w_extract = bus.dm_dout;
        endcase
    end

    always_comb begin
        w_merge = r_cap;
        case (r_size)
            2'b00:   w_merge[w_byte_base +: 8]  = r_wdata[7:0];
            2'b01:   w_merge[w_half_base +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.err     = (r_state == DONE) && r_err;
    assign bus.rdata   = r_rdata;
    assign bus.dm_we   = (r_state == WR);
    assign bus.dm_din  = (r_state == WR) ? w_merge : 32'd0;
    assign bus.dm_addr = (r_state == RD || r_state == RCAP || r_state == WR) ?
                         w_aligned : '0;
endmodule
`default_nettype wire
